// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the 2-way cache
// miss-handling controller.
package cache_pkg;

    localparam int unsigned OFFSET_W = 3;
    localparam int unsigned INDEX_W  = 6;
    localparam int unsigned TAG_W    = 30 - OFFSET_W - INDEX_W;
    localparam int unsigned BLOCK_W  = 32 << OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        VICTIM,
        WRITEBACK,
        ALLOCATE,
        INSTALL,
        DONE
    } cache_state_e;

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
        return addr >> (2 + off_w + idx_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned off_w,
                                               input int unsigned idx_w);
        return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr,
                                              input int unsigned off_w);
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_ctrl_2way.sv
// Miss-handling controller for a 2-way set-associative cache: compare, victim
// read, optional dirty writeback, refill, install and replay of one CPU access.
module cache_ctrl_2way
    import cache_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH = OFFSET_W,
    parameter int unsigned INDEX_WIDTH  = INDEX_W,
    parameter int unsigned TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
    parameter int unsigned BLOCK_BITS   = 32 << OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_byte_en,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ready,
    output logic                    ca_enable,
    output logic                    ca_cmp,
    output logic                    ca_write,
    output logic                    ca_valid_in,
    output logic [TAG_WIDTH-1:0]    ca_tag_in,
    output logic [INDEX_WIDTH-1:0]  ca_index,
    output logic [OFFSET_WIDTH-1:0] ca_word_sel,
    output logic [3:0]              ca_byte_w_en,
    output logic [31:0]             ca_data_in,
    output logic [BLOCK_BITS-1:0]   ca_data_block_in,
    input  logic                    ca_hit,
    input  logic                    ca_dirty,
    input  logic                    ca_valid_out,
    input  logic [TAG_WIDTH-1:0]    ca_tag_out,
    input  logic [31:0]             ca_data_out,
    input  logic [BLOCK_BITS-1:0]   ca_data_wb,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [BLOCK_BITS-1:0]   mem_wdata,
    input  logic [BLOCK_BITS-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    localparam int unsigned LOW_W = OFFSET_WIDTH + 2;

    cache_state_e state_q, state_d;

    logic [TAG_WIDTH-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [OFFSET_WIDTH-1:0] word_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic [TAG_WIDTH-1:0]    vtag_q;
    logic [BLOCK_BITS-1:0]   vblock_q;
    logic [BLOCK_BITS-1:0]   rblock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            index_q  <= '0;
            word_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            vtag_q   <= '0;
            vblock_q <= '0;
            rblock_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        tag_q   <= TAG_WIDTH'(addr_tag(cpu_addr, OFFSET_WIDTH, INDEX_WIDTH));
                        index_q <= INDEX_WIDTH'(addr_index(cpu_addr, OFFSET_WIDTH, INDEX_WIDTH));
                        word_q  <= OFFSET_WIDTH'(addr_word(cpu_addr, OFFSET_WIDTH));
                        we_q    <= cpu_we;
                        be_q    <= cpu_byte_en;
                        wdata_q <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (ca_hit && !we_q) rdata_q <= ca_data_out;
                end
                VICTIM: begin
                    vtag_q   <= ca_tag_out;
                    vblock_q <= ca_data_wb;
                end
                ALLOCATE: begin
                    // Only a completed refill is captured; an abandoned one never reaches INSTALL.
                    if (mem_ack) rblock_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata        = rdata_q;
    assign ca_tag_in        = tag_q;
    assign ca_index         = index_q;
    assign ca_word_sel      = word_q;
    assign ca_byte_w_en     = be_q;
    assign ca_data_in       = wdata_q;
    assign ca_data_block_in = rblock_q;

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        ca_enable   = 1'b0;
        ca_cmp      = 1'b0;
        ca_write    = 1'b0;
        ca_valid_in = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req) state_d = COMPARE;
            end
            COMPARE: begin
                ca_enable = 1'b1;
                ca_cmp    = 1'b1;
                ca_write  = we_q;
                state_d   = ca_hit ? DONE : VICTIM;
            end
            VICTIM: begin
                ca_enable = 1'b1;
                state_d   = (ca_valid_out && ca_dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vtag_q, index_q, {LOW_W{1'b0}}};
                mem_wdata = vblock_q;
                if (mem_ack) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q, {LOW_W{1'b0}}};
                if (mem_ack) state_d = INSTALL;
            end
            INSTALL: begin
                ca_enable   = 1'b1;
                ca_write    = 1'b1;
                ca_valid_in = 1'b1;
                state_d     = COMPARE;
            end
            DONE: begin
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench: behavioural 2-way array and memory around the controller,
// checked against a transparent-memory / LRU-set reference model.
module tb_cache_ctrl_2way;

    localparam int unsigned OW = 3;
    localparam int unsigned IW = 6;
    localparam int unsigned TW = 21;
    localparam int unsigned BW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]   cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]    cpu_byte_en = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          ca_enable, ca_cmp, ca_write, ca_valid_in;
    logic [TW-1:0] ca_tag_in;
    logic [IW-1:0] ca_index;
    logic [OW-1:0] ca_word_sel;
    logic [3:0]    ca_byte_w_en;
    logic [31:0]   ca_data_in;
    logic [BW-1:0] ca_data_block_in;
    logic          ca_hit, ca_dirty, ca_valid_out;
    logic [TW-1:0] ca_tag_out;
    logic [31:0]   ca_data_out;
    logic [BW-1:0] ca_data_wb;
    logic          mem_req, mem_we, mem_ack;
    logic [31:0]   mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl_2way #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ca_enable(ca_enable), .ca_cmp(ca_cmp), .ca_write(ca_write),
        .ca_valid_in(ca_valid_in), .ca_tag_in(ca_tag_in), .ca_index(ca_index),
        .ca_word_sel(ca_word_sel), .ca_byte_w_en(ca_byte_w_en),
        .ca_data_in(ca_data_in), .ca_data_block_in(ca_data_block_in),
        .ca_hit(ca_hit), .ca_dirty(ca_dirty), .ca_valid_out(ca_valid_out),
        .ca_tag_out(ca_tag_out), .ca_data_out(ca_data_out), .ca_data_wb(ca_data_wb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return wa * 32'h9E37_79B9 + 32'h0000_1000;
    endfunction

    // ---------------- behavioural 2-way array (true LRU) ----------------
    logic [31:0]   a_data [2][64][8];
    logic [TW-1:0] a_tag  [2][64];
    logic          a_val  [2][64];
    logic          a_dirty[2][64];
    logic          a_lru  [64];
    logic          h0, h1, way;

    always_comb begin
        h0 = a_val[0][ca_index] && (a_tag[0][ca_index] == ca_tag_in);
        h1 = a_val[1][ca_index] && (a_tag[1][ca_index] == ca_tag_in);
        way = ca_cmp ? h1 : a_lru[ca_index];
        ca_hit       = ca_enable && ca_cmp && (h0 || h1);
        ca_data_out  = a_data[way][ca_index][ca_word_sel];
        ca_tag_out   = a_tag[way][ca_index];
        ca_valid_out = a_val[way][ca_index];
        ca_dirty     = a_dirty[way][ca_index];
        ca_data_wb   = '0;
        for (int k = 0; k < 8; k++) ca_data_wb[32*k +: 32] = a_data[way][ca_index][k];
    end

    always @(posedge clk) begin
        if (ca_enable) begin
            if (ca_cmp && ca_hit) begin
                a_lru[ca_index] <= ~way;
                if (ca_write) begin
                    for (int b = 0; b < 4; b++)
                        if (ca_byte_w_en[b])
                            a_data[way][ca_index][ca_word_sel][8*b +: 8] <= ca_data_in[8*b +: 8];
                    a_dirty[way][ca_index] <= 1'b1;
                end
            end else if (!ca_cmp && ca_write) begin
                a_val[way][ca_index]   <= ca_valid_in;
                a_tag[way][ca_index]   <= ca_tag_in;
                a_dirty[way][ca_index] <= 1'b0;
                for (int k = 0; k < 8; k++)
                    a_data[way][ca_index][k] <= ca_data_block_in[32*k +: 32];
            end
        end
    end

    // ---------------- memory responder ----------------
    logic [31:0]   m_mem [int unsigned];
    int unsigned   mem_lat = 0;
    int unsigned   m_cnt;
    logic          ack_q;
    logic          spur_ack = 1'b0;
    logic [BW-1:0] rd_blk;
    logic [31:0]   wb_addr_q[$];
    logic [BW-1:0] wb_data_q[$];
    logic [31:0]   al_addr_q[$];

    assign mem_ack = ack_q | spur_ack;

    function automatic logic [31:0] m_rd(input int unsigned wa);
        if (m_mem.exists(wa)) return m_mem[wa];
        return init_word(wa);
    endfunction

    always @(posedge clk) begin
        if (rst || !mem_req || ack_q) begin
            ack_q <= 1'b0;
            m_cnt <= 0;
        end else if (m_cnt >= mem_lat) begin
            ack_q <= 1'b1;
            if (mem_we) begin
                wb_addr_q.push_back(mem_addr);
                wb_data_q.push_back(mem_wdata);
                for (int k = 0; k < 8; k++) m_mem[(mem_addr >> 2) + k] = mem_wdata[32*k +: 32];
            end else begin
                al_addr_q.push_back(mem_addr);
                for (int k = 0; k < 8; k++) rd_blk[32*k +: 32] = m_rd((mem_addr >> 2) + k);
                mem_rdata <= rd_blk;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- monitors ----------------
    int unsigned n_inst = 0, n_memreq = 0;
    logic        prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        if (ca_enable && ca_write && !ca_cmp) n_inst++;
        if (mem_req) n_memreq++;
        if (mem_req && !rst) begin
            check_eq("mem_addr_align", mem_addr[4:0], 5'd0);
            if (prev_req && !prev_ack) begin
                check_eq("mem_addr_hold", mem_addr, prev_addr);
                check_eq("mem_we_hold", mem_we, prev_we);
            end
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
        prev_we   = mem_we;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int unsigned];
    bit          ref_dirty [int unsigned];
    int unsigned ref_lru [64][$];

    function automatic logic [31:0] ref_rd(input int unsigned wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic bit ref_is_dirty(input int unsigned blk);
        if (ref_dirty.exists(blk)) return ref_dirty[blk];
        return 1'b0;
    endfunction

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input bit hold, input bit spur,
                             output logic [31:0] rd);
        int unsigned blk, idx, wa, exp_lat, n, vic;
        int unsigned inst0, req0, wb0, al0;
        int          pos;
        bit          hit, dirty_ev;
        logic [BW-1:0] exp_wb;
        logic [31:0]   w;
        blk = addr >> 5;
        idx = blk % 64;
        wa  = addr >> 2;
        hit = 1'b0; pos = 0; dirty_ev = 1'b0; vic = 0; exp_wb = '0;
        for (int i = 0; i < ref_lru[idx].size(); i++)
            if (ref_lru[idx][i] == blk) begin hit = 1'b1; pos = i; end
        if (hit) begin
            ref_lru[idx].delete(pos);
            exp_lat = 2;
        end else begin
            exp_lat = mem_lat + 7;
            if (ref_lru[idx].size() == 2) begin
                vic = ref_lru[idx].pop_front();
                if (ref_is_dirty(vic)) begin
                    dirty_ev = 1'b1;
                    exp_lat += mem_lat + 2;
                    for (int k = 0; k < 8; k++) exp_wb[32*k +: 32] = ref_rd(vic * 8 + k);
                end
                ref_dirty[vic] = 1'b0;
            end
        end
        ref_lru[idx].push_back(blk);
        inst0 = n_inst; req0 = n_memreq; wb0 = wb_addr_q.size(); al0 = al_addr_q.size();

        @(negedge clk);
        check_eq("ready_pulse", cpu_ready, 1'b0);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byte_en = be; cpu_wdata = wd;
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            spur_ack = (spur && hit && n == 1);
            if (cpu_ready || n >= 400) break;
        end
        spur_ack = 1'b0;
        check_eq("latency", n, exp_lat);
        rd = cpu_rdata;
        if (!we) check_eq("load_data", cpu_rdata, ref_rd(wa));
        if (!hold) cpu_req = 1'b0;

        check_eq("install_cnt", n_inst - inst0, hit ? 0 : 1);
        if (hit) check_eq("hit_no_memreq", n_memreq - req0, 0);
        check_eq("wb_cnt", wb_addr_q.size() - wb0, dirty_ev ? 1 : 0);
        if (dirty_ev && wb_addr_q.size() > wb0) begin
            check_eq("wb_addr", wb_addr_q[wb0], vic << 5);
            check_eq("wb_data", wb_data_q[wb0], exp_wb);
        end
        check_eq("alloc_cnt", al_addr_q.size() - al0, hit ? 0 : 1);
        if (!hit && al_addr_q.size() > al0) check_eq("alloc_addr", al_addr_q[al0], blk << 5);

        if (we) begin
            w = ref_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[wa] = w;
            ref_dirty[blk] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0]   rd;
        logic [BW-1:0] last_wb;
        int unsigned   n, inst0, tag, idx, wrd;
        int unsigned   idx_tab[3];
        idx_tab[0] = 2; idx_tab[1] = 4; idx_tab[2] = 9;
        for (int w2 = 0; w2 < 2; w2++)
            for (int s = 0; s < 64; s++) begin
                a_val[w2][s] = 1'b0; a_dirty[w2][s] = 1'b0; a_tag[w2][s] = '0;
                for (int k = 0; k < 8; k++) a_data[w2][s][k] = '0;
            end
        for (int s = 0; s < 64; s++) a_lru[s] = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_cpu_ready", cpu_ready, 1'b0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rst_ca_ctrl", {ca_enable, ca_cmp, ca_write, ca_valid_in}, 4'd0);
        check_eq("rst_ca_fields", {ca_tag_in, ca_index, ca_word_sel, ca_byte_w_en}, '0);
        check_eq("rst_mem_req", {mem_req, mem_we}, 2'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a refill
        mem_lat = 30;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040; cpu_byte_en = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && !mem_we) && n < 50);
        check_eq("reach_alloc", mem_req && !mem_we, 1'b1);
        inst0 = n_inst;
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_mem_req", mem_req, 1'b0);
        check_eq("rst_mid_ready", cpu_ready, 1'b0);
        check_eq("rst_mid_ca_enable", ca_enable, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_no_install", n_inst - inst0, 0);
        check_eq("rst_mid_no_refill", al_addr_q.size(), 0);

        // cold load miss, then hit with a stray ack in COMPARE
        mem_lat = 5;
        do_access(1'b0, 32'h0000_1040, 4'hF, 32'd0, 1'b0, 1'b0, rd);
        check_eq("cold_word0", rd, init_word(32'h1040 >> 2));
        do_access(1'b0, 32'h0000_1040, 4'hF, 32'd0, 1'b0, 1'b1, rd);

        // store hit, then two conflicting misses force a dirty writeback
        mem_lat = 2;
        do_access(1'b1, 32'h0000_1040, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, rd);
        do_access(1'b0, 32'h0000_2040, 4'hF, 32'd0, 1'b0, 1'b0, rd);
        do_access(1'b0, 32'h0000_3040, 4'hF, 32'd0, 1'b0, 1'b0, rd);
        check_eq("evict_wb_total", wb_addr_q.size(), 1);
        if (wb_data_q.size() > 0) begin
            last_wb = wb_data_q[0];
            check_eq("evict_wb_word0", last_wb[31:0], 32'hDEAD_BEEF);
        end
        do_access(1'b0, 32'h0000_1040, 4'hF, 32'd0, 1'b0, 1'b0, rd);
        check_eq("evict_reload", rd, 32'hDEAD_BEEF);

        // partial store
        do_access(1'b1, 32'h0000_4084, 4'hF, 32'h1111_1111, 1'b0, 1'b0, rd);
        do_access(1'b1, 32'h0000_4084, 4'b0011, 32'h0000_5555, 1'b0, 1'b0, rd);
        do_access(1'b0, 32'h0000_4084, 4'hF, 32'd0, 1'b0, 1'b0, rd);
        check_eq("partial_store", rd, 32'h1111_5555);

        // cpu_req held through DONE starts a second access
        do_access(1'b0, 32'h0000_4084, 4'hF, 32'd0, 1'b1, 1'b0, rd);
        do_access(1'b0, 32'h0000_4084, 4'hF, 32'd0, 1'b0, 1'b0, rd);

        // randomized traffic over a few conflicting sets
        for (int t = 0; t < 200; t++) begin
            mem_lat = $urandom_range(0, 4);
            tag = $urandom_range(0, 3);
            idx = idx_tab[$urandom_range(0, 2)];
            wrd = $urandom_range(0, 7);
            do_access(1'($urandom_range(0, 1)),
                      ((tag * 64 + idx) << 5) | (wrd << 2) | $urandom_range(0, 3),
                      4'($urandom_range(1, 15)), $urandom,
                      1'b0, 1'($urandom_range(0, 1)), rd);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
